// File: rtl/scp_pkg.sv
// scp_pkg: shared types for the SCP register-file/ALU sequencer
// (state encoding, ALU function codes, op queue entry).
package scp_pkg;
  localparam int SCP_DATA_W = 32;
  localparam int SCP_REG_AW = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_e;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  typedef struct packed {
    logic [3:0]            func;
    logic [SCP_REG_AW-1:0] rd;
    logic [SCP_REG_AW-1:0] rs1;
    logic [SCP_REG_AW-1:0] rs2;
    logic [SCP_DATA_W-1:0] imm;
    logic                  use_imm;
  } op_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, power-of-2 depth, pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    full = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata;
  end
  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/rf_alu_sequencer.sv
// rf_alu_sequencer: queues decoded ALU ops and runs each through READ/EXEC/WB.
// Define RF_ALU_PERF_CNT_EN to enable the retireCount performance counter.
module rf_alu_sequencer
  import scp_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int DATA_W = SCP_DATA_W,
  parameter int REG_AW = SCP_REG_AW
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              opValid,
  output logic              opReady,
  input  logic [3:0]        opAluFunc,
  input  logic [REG_AW-1:0] opRd,
  input  logic [REG_AW-1:0] opRs1,
  input  logic [REG_AW-1:0] opRs2,
  input  logic [DATA_W-1:0] opImm,
  input  logic              opUseImm,
  output logic [REG_AW-1:0] rfRdAddr1,
  output logic [REG_AW-1:0] rfRdAddr2,
  input  logic [DATA_W-1:0] rfRdData1,
  input  logic [DATA_W-1:0] rfRdData2,
  output logic              rfWrEn,
  output logic [REG_AW-1:0] rfWrAddr,
  output logic [DATA_W-1:0] rfWrData,
  output logic [3:0]        aluFunc,
  output logic [DATA_W-1:0] aluA,
  output logic [DATA_W-1:0] aluB,
  input  logic [DATA_W-1:0] aluResult,
  output logic              retire,
  output logic              busy,
  output logic [31:0]       retireCount
);
  localparam int CW = $clog2(QDEPTH) + 1;
  state_e state_q, state_d;
  op_t in_op, head;
  logic full, empty, push, pop;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic [3:0] func_q, func_d;
  assign in_op = '{func: opAluFunc, rd: opRd, rs1: opRs1, rs2: opRs2, imm: opImm, use_imm: opUseImm};
  assign push = opValid && opReady;
  sync_fifo #(.WIDTH($bits(op_t)), .DEPTH(QDEPTH)) u_queue (
    .clk(clk), .rst_n(reset_n), .push(push), .pop(pop), .wdata(in_op),
    .rdata(head), .full(full), .empty(empty), .count(count)
  );
  always_comb begin
    state_d = state_q;
    opa_d = opa_q;
    opb_d = opb_q;
    res_d = res_q;
    func_d = func_q;
    pop = 1'b0;
    case (state_q)
      IDLE: state_d = empty ? IDLE : READ;
      READ: begin
        opa_d = rfRdData1;
        opb_d = head.use_imm ? head.imm : rfRdData2;
        state_d = EXEC;
      end
      EXEC: begin
        func_d = head.func;
        res_d = aluResult;
        state_d = WB;
      end
      WB: begin
        pop = 1'b1;
        // a push landing with this pop keeps the queue non-empty
        state_d = (count > CW'(1) || push) ? READ : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      opa_q <= '0;
      opb_q <= '0;
      res_q <= '0;
      func_q <= '0;
    end else begin
      state_q <= state_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      res_q <= res_d;
      func_q <= func_d;
    end
  end
  always_comb begin
    opReady = !full;
    retire = state_q == WB;
    busy = state_q != IDLE || !empty;
    rfRdAddr1 = state_q == READ ? head.rs1 : '0;
    rfRdAddr2 = state_q == READ ? head.rs2 : '0;
    rfWrEn = retire && head.rd != '0;
    rfWrAddr = retire ? head.rd : '0;
    rfWrData = retire ? res_q : '0;
    aluFunc = state_q == EXEC ? head.func : func_q;
    aluA = opa_q;
    aluB = opb_q;
  end
`ifdef RF_ALU_PERF_CNT_EN
  logic [31:0] rcnt_q, rcnt_d;
  assign rcnt_d = rcnt_q + 32'(retire);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rcnt_q <= '0;
    else rcnt_q <= rcnt_d;
  end
  assign retireCount = rcnt_q;
`else
  assign retireCount = '0;
`endif
endmodule
